// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_deserializer
// Brief   : Oversampled UART receiver with programmable ratio, length and
//           parity, break/framing/overrun detection and valid/ready output.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int DATA_W      = 8,
    parameter int OSR_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              bclk_in,
    input  logic              rstn_in,
    input  logic              enable_in,
    input  logic              serial_in,
    input  logic [OSR_W-1:0]  osr_in,
    input  logic [3:0]        dlen_in,
    input  logic              pen_in,
    input  logic              eps_in,
    input  logic              sp_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    input  logic              data_ready_in,
    output logic              pe_out,
    output logic              fe_out,
    output logic              bi_out,
    output logic              oe_out,
    output logic              busy_out,
    output logic              cfg_err_out
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_BRK_WAIT = 3'd5;

    localparam logic [OSR_W-1:0] C_OSR_MIN  = OSR_W'(4);
    localparam logic [OSR_W-1:0] C_OSR_ONE  = OSR_W'(1);
    localparam logic [3:0]       C_DLEN_MIN = 4'd5;
    localparam logic [3:0]       C_DLEN_MAX = 4'(DATA_W);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [OSR_W-1:0]       r_cnt;
    logic [OSR_W-1:0]       r_osr;
    logic [3:0]             r_dlen;
    logic [3:0]             r_bit_idx;
    logic                   r_pen;
    logic                   r_eps;
    logic                   r_sp;
    logic                   r_s1;
    logic                   r_s2;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_par_bit;
    logic                   r_pe_pend;

    logic                   w_rx;
    logic [OSR_W-1:0]       w_half;
    logic [OSR_W-1:0]       w_half_m1;
    logic [OSR_W-1:0]       w_half_p1;
    logic [OSR_W-1:0]       w_cnt_next;
    logic                   w_in_frame;
    logic                   w_decide;
    logic                   w_bit;
    logic                   w_par_exp;
    logic                   w_brk;
    logic                   w_accept;
    logic [DATA_W-1:0]      w_shift_next;

    assign w_rx        = r_sync[SYNC_STAGES-1];
    assign cfg_err_out = (osr_in < C_OSR_MIN) | (dlen_in < C_DLEN_MIN) | (dlen_in > C_DLEN_MAX);
    assign busy_out    = (r_state != ST_IDLE);

    assign w_half     = r_osr >> 1;
    assign w_half_m1  = w_half - C_OSR_ONE;
    assign w_half_p1  = w_half + C_OSR_ONE;
    assign w_cnt_next = (r_cnt == r_osr - C_OSR_ONE) ? '0 : r_cnt + C_OSR_ONE;
    assign w_in_frame = (r_state == ST_START) | (r_state == ST_DATA) |
                        (r_state == ST_PARITY) | (r_state == ST_STOP);
    assign w_decide   = w_in_frame & (r_cnt == w_half_p1);

    // Third vote is the live sample taken on the decision tick itself
    assign w_bit      = (r_s1 & r_s2) | (r_s1 & w_rx) | (r_s2 & w_rx);
    assign w_par_exp  = r_sp ? ~r_eps : (r_eps ? ^r_shift : ~^r_shift);
    assign w_brk      = (r_shift == '0) & (~r_pen | ~r_par_bit) & ~w_bit;
    assign w_accept   = data_valid_out & data_ready_in;

    always_comb begin
        w_shift_next = r_shift;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_bit_idx == 4'(i)) begin
                w_shift_next[i] = w_bit;
            end
        end
    end

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_sync         <= '1;
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_osr          <= '0;
            r_dlen         <= '0;
            r_bit_idx      <= '0;
            r_pen          <= 1'b0;
            r_eps          <= 1'b0;
            r_sp           <= 1'b0;
            r_s1           <= 1'b0;
            r_s2           <= 1'b0;
            r_shift        <= '0;
            r_par_bit      <= 1'b0;
            r_pe_pend      <= 1'b0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            pe_out         <= 1'b0;
            fe_out         <= 1'b0;
            bi_out         <= 1'b0;
            oe_out         <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], serial_in};
            oe_out <= 1'b0;
            if (w_accept) begin
                data_valid_out <= 1'b0;
            end

            if (!enable_in) begin
                r_state <= ST_IDLE;
            end else begin
                if (w_in_frame) begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == w_half_m1) r_s1 <= w_rx;
                    if (r_cnt == w_half)    r_s2 <= w_rx;
                end

                case (r_state)
                    ST_IDLE: begin
                        if (!cfg_err_out && !w_rx) begin
                            r_state   <= ST_START;
                            r_cnt     <= '0;
                            r_osr     <= osr_in;
                            r_dlen    <= dlen_in;
                            r_pen     <= pen_in;
                            r_eps     <= eps_in;
                            r_sp      <= sp_in;
                            r_shift   <= '0;
                            r_bit_idx <= '0;
                            r_par_bit <= 1'b0;
                            r_pe_pend <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (w_decide) begin
                            r_state <= w_bit ? ST_IDLE : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (w_decide) begin
                            r_shift <= w_shift_next;
                            if (r_bit_idx == r_dlen - 4'd1) begin
                                r_state <= r_pen ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 4'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_decide) begin
                            r_par_bit <= w_bit;
                            r_pe_pend <= w_bit ^ w_par_exp;
                            r_state   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (w_decide) begin
                            r_state <= w_brk ? ST_BRK_WAIT : ST_IDLE;
                            // A char accepted this cycle frees the holding slot
                            if (!data_valid_out || data_ready_in) begin
                                data_out       <= r_shift;
                                pe_out         <= r_pe_pend;
                                fe_out         <= ~w_bit;
                                bi_out         <= w_brk;
                                data_valid_out <= 1'b1;
                            end else begin
                                oe_out <= 1'b1;
                            end
                        end
                    end
                    ST_BRK_WAIT: begin
                        if (w_rx) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_deserializer
// Brief   : Scoreboard bench for uart_rx_deserializer: directed and random
//           frames, expected characters queued at send time.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

    localparam int DATA_W      = 8;
    localparam int OSR_W       = 5;
    localparam int SYNC_STAGES = 2;

    logic              bclk_in       = 1'b0;
    logic              rstn_in       = 1'b0;
    logic              enable_in     = 1'b0;
    logic              serial_in     = 1'b1;
    logic [OSR_W-1:0]  osr_in        = 5'd16;
    logic [3:0]        dlen_in       = 4'd8;
    logic              pen_in        = 1'b0;
    logic              eps_in        = 1'b0;
    logic              sp_in         = 1'b0;
    logic              data_ready_in = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid_out;
    logic              pe_out;
    logic              fe_out;
    logic              bi_out;
    logic              oe_out;
    logic              busy_out;
    logic              cfg_err_out;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              pe;
        logic              fe;
        logic              bi;
    } exp_t;

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   oe_cnt    = 0;
    int   rise_cnt  = 0;
    int   rise_cyc  = 0;
    int   cyc       = 0;
    bit   prev_v    = 1'b0;
    bit   rand_ready = 1'b0;

    uart_rx_deserializer #(
        .DATA_W      (DATA_W),
        .OSR_W       (OSR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .bclk_in        (bclk_in),
        .rstn_in        (rstn_in),
        .enable_in      (enable_in),
        .serial_in      (serial_in),
        .osr_in         (osr_in),
        .dlen_in        (dlen_in),
        .pen_in         (pen_in),
        .eps_in         (eps_in),
        .sp_in          (sp_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .pe_out         (pe_out),
        .fe_out         (fe_out),
        .bi_out         (bi_out),
        .oe_out         (oe_out),
        .busy_out       (busy_out),
        .cfg_err_out    (cfg_err_out)
    );

    always #5 bclk_in = ~bclk_in;
    always @(posedge bclk_in) cyc++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted character
    always @(negedge bclk_in) begin
        exp_t e;
        if (oe_out) oe_cnt++;
        if (data_valid_out && !prev_v) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_v = data_valid_out;
        if (rstn_in && data_valid_out && data_ready_in) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_char: got 0x%0h expected no character", data_out);
            end else begin
                e = exp_q.pop_front();
                check("char_data", 32'(data_out), 32'(e.data));
                check("char_pe",   32'(pe_out),   32'(e.pe));
                check("char_fe",   32'(fe_out),   32'(e.fe));
                check("char_bi",   32'(bi_out),   32'(e.bi));
            end
        end
    end

    initial begin
        forever begin
            @(posedge bclk_in);
            #1;
            if (rand_ready) data_ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    // Each call starts and ends 1 time unit after a rising edge
    task automatic drive_bit(input bit v, input int n);
        serial_in = v;
        repeat (n) @(posedge bclk_in);
        #1;
    endtask

    task automatic send_frame(input int osr, input int dlen, input bit pen, input bit eps,
                              input bit sp, input logic [DATA_W-1:0] data, input bit flip_par,
                              input bit stop, input bit expect_out, input bit scramble);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] d;
        int   ones;
        bit   par_ok;
        bit   par_sent;
        exp_t e;
        mask = '0;
        for (int i = 0; i < dlen; i++) mask[i] = 1'b1;
        d        = data & mask;
        ones     = $countones(d);
        par_ok   = sp ? !eps : (eps ? ones[0] : !ones[0]);
        par_sent = par_ok ^ flip_par;
        e.data   = d;
        e.pe     = pen && (par_sent != par_ok);
        e.fe     = !stop;
        e.bi     = (d == '0) && (!pen || !par_sent) && !stop;
        osr_in   = OSR_W'(osr);
        dlen_in  = 4'(dlen);
        pen_in   = pen;
        eps_in   = eps;
        sp_in    = sp;
        if (expect_out) exp_q.push_back(e);
        drive_bit(1'b0, osr);
        if (scramble) begin
            osr_in  = OSR_W'($urandom_range(0, 31));
            dlen_in = 4'($urandom_range(0, 15));
            pen_in  = 1'($urandom_range(0, 1));
            eps_in  = 1'($urandom_range(0, 1));
            sp_in   = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < dlen; i++) drive_bit(d[i], osr);
        if (pen) drive_bit(par_sent, osr);
        osr_in  = OSR_W'(osr);
        dlen_in = 4'(dlen);
        pen_in  = pen;
        eps_in  = eps;
        sp_in   = sp;
        drive_bit(stop, osr);
        drive_bit(1'b1, 2 * osr + $urandom_range(0, 7));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge bclk_in);
            n++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int start_cyc;
        int oe_base;
        int rise_base;
        logic [DATA_W-1:0] rd;

        rstn_in = 1'b0;
        repeat (3) @(posedge bclk_in);
        #1;
        rstn_in   = 1'b1;
        enable_in = 1'b1;
        data_ready_in = 1'b1;
        check("rst_valid",   32'(data_valid_out), 32'd0);
        check("rst_data",    32'(data_out),       32'd0);
        check("rst_flags",   32'({pe_out, fe_out, bi_out, oe_out}), 32'd0);
        check("rst_busy",    32'(busy_out),       32'd0);
        check("rst_cfg_err", 32'(cfg_err_out),    32'd0);
        drive_bit(1'b1, 4);

        // 8N1 0xA5 with latency measured from the serial falling edge
        start_cyc = cyc;
        send_frame(16, 8, 0, 0, 0, 8'hA5, 0, 1, 1, 0);
        check("latency", 32'(rise_cyc - start_cyc), 32'(SYNC_STAGES + 1 + 8 + 2 + 16 * 9));
        wait_drain(100);

        // 7E1 0x41 with a wrong parity bit
        send_frame(16, 7, 1, 1, 0, 8'h41, 1, 1, 1, 0);
        wait_drain(100);

        // Short glitch is rejected as a false start
        rise_base = rise_cnt;
        serial_in = 1'b0;
        repeat (4) @(posedge bclk_in);
        #1;
        check("glitch_busy_high", 32'(busy_out), 32'd1);
        serial_in = 1'b1;
        repeat (9) @(posedge bclk_in);
        #1;
        check("glitch_idle", 32'(busy_out), 32'd0);
        drive_bit(1'b1, 20);
        check("glitch_no_valid", 32'(rise_cnt - rise_base), 32'd0);

        // Line held low three frames: one break char then wait for idle
        rise_base = rise_cnt;
        exp_q.push_back('{data: '0, pe: 1'b0, fe: 1'b1, bi: 1'b1});
        drive_bit(1'b0, 3 * 10 * 16);
        check("break_one_char", 32'(rise_cnt - rise_base), 32'd1);
        check("break_wait_busy", 32'(busy_out), 32'd1);
        drive_bit(1'b1, 20);
        check("break_released", 32'(busy_out), 32'd0);
        send_frame(16, 8, 0, 0, 0, 8'h55, 0, 1, 1, 0);
        wait_drain(100);

        // Overrun: consumer stalls across two frames
        data_ready_in = 1'b0;
        oe_base = oe_cnt;
        send_frame(16, 8, 0, 0, 0, 8'h11, 0, 1, 1, 0);
        send_frame(16, 8, 0, 0, 0, 8'h22, 0, 1, 0, 0);
        check("ovr_oe_once",  32'(oe_cnt - oe_base), 32'd1);
        check("ovr_held",     32'(data_out),         32'h11);
        check("ovr_valid",    32'(data_valid_out),   32'd1);
        data_ready_in = 1'b1;
        @(posedge bclk_in);
        #1;
        check("ovr_cleared",  32'(data_valid_out),   32'd0);
        wait_drain(10);

        // osr=13 5-bit stick parity, then illegal configurations
        send_frame(13, 5, 1, 0, 1, 8'h1F, 0, 1, 1, 0);
        wait_drain(100);
        dlen_in = 4'd4;
        #1;
        check("cfg_err_dlen4", 32'(cfg_err_out), 32'd1);
        drive_bit(1'b0, 13);
        check("cfg_err_no_start", 32'(busy_out), 32'd0);
        drive_bit(1'b1, 30);
        dlen_in = 4'd8;
        osr_in  = 5'd3;
        #1;
        check("cfg_err_osr3", 32'(cfg_err_out), 32'd1);
        osr_in  = 5'd16;
        #1;
        check("cfg_ok", 32'(cfg_err_out), 32'd0);

        // Enable dropped mid-frame discards the partial char
        rise_base = rise_cnt;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        enable_in = 1'b0;
        @(posedge bclk_in);
        #1;
        check("enable_abort_idle", 32'(busy_out), 32'd0);
        drive_bit(1'b1, 200);
        enable_in = 1'b1;
        check("enable_abort_no_valid", 32'(rise_cnt - rise_base), 32'd0);

        // Asynchronous reset mid-frame
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 4);
        check("areset_pre_busy", 32'(busy_out), 32'd1);
        #2;
        rstn_in = 1'b0;
        #1;
        check("areset_busy", 32'(busy_out), 32'd0);
        serial_in = 1'b1;
        @(posedge bclk_in);
        #1;
        rstn_in = 1'b1;
        drive_bit(1'b1, 20);

        // Randomized frames with a stalling consumer and mid-frame config churn
        oe_base = oe_cnt;
        rand_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            rd = ($urandom_range(0, 5) == 0) ? '0 : DATA_W'($urandom);
            send_frame($urandom_range(6, 31), $urandom_range(5, DATA_W),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), rd,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                       1, 1);
        end
        rand_ready = 1'b0;
        #2;
        data_ready_in = 1'b1;
        @(posedge bclk_in);
        #1;
        wait_drain(200);
        check("random_no_oe", 32'(oe_cnt - oe_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
